// File: rtl/rs_issue_scheduler.sv
// Reservation-station allocation and oldest-ready issue select for an 8-entry station array.
// Per-entry operand tracking lives in rs_entry; the top does free-slot pick, age select and counting.

module rs_entry #(
    parameter int ENTRIES = 8,
    parameter int TAGW    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               alloc,
    input  logic               retire,
    input  logic [TAGW-1:0]    dispTagA,
    input  logic               dispVa,
    input  logic [TAGW-1:0]    dispTagB,
    input  logic               dispVb,
    input  logic               cdbValid,
    input  logic [TAGW-1:0]    cdbTag,
    input  logic [ENTRIES-1:0] busyMask,
    input  logic [ENTRIES-1:0] colClear,
    output logic               busy,
    output logic               opA,
    output logic               opB,
    output logic [ENTRIES-1:0] olderRow
);
    logic [TAGW-1:0] tagA, tagB;
    logic            wakeA, wakeB, bypA, bypB;

    assign wakeA = cdbValid && (cdbTag == tagA);
    assign wakeB = cdbValid && (cdbTag == tagB);
    // a broadcast on the allocation edge would otherwise be missed forever
    assign bypA  = cdbValid && (cdbTag == dispTagA);
    assign bypB  = cdbValid && (cdbTag == dispTagB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            opA      <= 1'b0;
            opB      <= 1'b0;
            tagA     <= '0;
            tagB     <= '0;
            olderRow <= '0;
        end else if (flush) begin
            busy     <= 1'b0;
            opA      <= 1'b0;
            opB      <= 1'b0;
            olderRow <= '0;
        end else if (alloc) begin
            busy     <= 1'b1;
            tagA     <= dispTagA;
            tagB     <= dispTagB;
            opA      <= dispVa | bypA;
            opB      <= dispVb | bypB;
            olderRow <= busyMask & ~colClear;
        end else begin
            olderRow <= olderRow & ~colClear;
            if (retire)
                busy <= 1'b0;
            if (busy && !opA && wakeA)
                opA <= 1'b1;
            if (busy && !opB && wakeB)
                opB <= 1'b1;
        end
    end
endmodule

module rs_issue_scheduler #(
    parameter int ENTRIES = 8,
    parameter int IDXW    = 3,
    parameter int TAGW    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_valid,
    output logic               disp_ready,
    output logic [IDXW-1:0]    disp_idx,
    input  logic [TAGW-1:0]    disp_tag_a,
    input  logic               disp_va,
    input  logic [TAGW-1:0]    disp_tag_b,
    input  logic               disp_vb,
    input  logic               cdb_valid,
    input  logic [TAGW-1:0]    cdb_tag,
    output logic               issue_valid,
    output logic [IDXW-1:0]    issue_idx,
    input  logic               issue_ready,
    input  logic               flush,
    output logic [ENTRIES-1:0] busy_mask,
    output logic [IDXW:0]      free_count
);
    logic [ENTRIES-1:0]              busyV, vaV, vbV, readyV, grant;
    logic [ENTRIES-1:0]              issueCol, dispCol, colClear;
    logic [ENTRIES-1:0][ENTRIES-1:0] olderM;
    logic                            dispFire, issueFire;

    assign readyV    = busyV & vaV & vbV;
    assign dispFire  = disp_valid && disp_ready;
    assign issueFire = issue_valid && issue_ready;
    assign issueCol  = issueFire ? grant : '0;
    assign colClear  = issueCol | dispCol;

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : gEnt
            // ages are unique among busy entries, so at most one grant bit is set
            assign grant[g] = readyV[g] && ((olderM[g] & readyV) == '0);

            rs_entry #(.ENTRIES(ENTRIES), .TAGW(TAGW)) uEnt (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .alloc    (dispCol[g]),
                .retire   (issueCol[g]),
                .dispTagA (disp_tag_a),
                .dispVa   (disp_va),
                .dispTagB (disp_tag_b),
                .dispVb   (disp_vb),
                .cdbValid (cdb_valid),
                .cdbTag   (cdb_tag),
                .busyMask (busyV),
                .colClear (colClear),
                .busy     (busyV[g]),
                .opA      (vaV[g]),
                .opB      (vbV[g]),
                .olderRow (olderM[g])
            );
        end
    endgenerate

    always_comb begin
        disp_idx   = '0;
        issue_idx  = '0;
        free_count = '0;
        dispCol    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!busyV[i])
                disp_idx = IDXW'(i);
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant[i])
                issue_idx = issue_idx | IDXW'(i);
            free_count = free_count + (IDXW + 1)'(!busyV[i]);
        end
        if (dispFire)
            dispCol[disp_idx] = 1'b1;
    end

    assign disp_ready  = !(&busyV);
    assign issue_valid = |readyV;
    assign busy_mask   = busyV;
endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Allocation and issue controller for the 8-entry reservation-station array.
- Allocates a free entry for each dispatched instruction and tracks operand readiness from CDB tag broadcasts.
- Each cycle, selects the oldest entry whose operands are both valid and offers it to the ALU under a valid/ready handshake.
- Outputs entry indices only; the station storage (data, RegD, ALU code, PC) is addressed by disp_idx and issue_idx.

Parameters:
- ENTRIES, 8, number of station entries.
- IDXW, 3, entry index width; clog2(ENTRIES).
- TAGW, 6, producer tag width; matches the 6-bit RegA/RegB tag fields.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- disp_valid  input  1  dispatch request.
- disp_ready  output  1  at least one entry free.
- disp_idx  output  IDXW  entry that will be allocated (lowest-index free entry).
- disp_tag_a  input  TAGW  producer tag for operand A.
- disp_va  input  1  operand A already valid.
- disp_tag_b  input  TAGW  producer tag for operand B.
- disp_vb  input  1  operand B already valid.
- cdb_valid  input  1  result broadcast valid.
- cdb_tag  input  TAGW  broadcast producer tag.
- issue_valid  output  1  a ready entry is offered.
- issue_idx  output  IDXW  entry offered to the ALU.
- issue_ready  input  1  ALU accepts this cycle.
- flush  input  1  synchronous clear of all entries (mispredict recovery).
- busy_mask  output  ENTRIES  per-entry occupied flags.
- free_count  output  IDXW+1  number of free entries, 0..ENTRIES.

Behaviour:
- Per-entry state: busy, va, vb, tag_a, tag_b. Age matrix older[i][j] = 1 when entry j was allocated before entry i and is still busy.
- Reset (async, reset=0): busy=0, va=vb=0, age matrix=0. Resulting outputs: disp_ready=1, disp_idx=0, issue_valid=0, issue_idx=0, busy_mask=0, free_count=ENTRIES.
- All outputs are combinational from registered state only. No output depends on disp_*, cdb_* or issue_ready in the same cycle.
- Dispatch fires on a rising edge when disp_valid & disp_ready. Entry disp_idx is written with busy=1 and the operand tags and valid flags. Row older[disp_idx] is set to busy_mask before the edge; column disp_idx is cleared in every other row.
- Dispatch CDB bypass: if cdb_valid and cdb_tag equals a not-yet-valid dispatch tag on the same edge, that operand is stored with its valid flag = 1.
- Wakeup: on each edge with cdb_valid, every busy entry with va=0 and tag_a=cdb_tag sets va=1. Operand B is handled the same way.
- Ready = busy & va & vb.
- Select: issue_idx is the ready entry with no older ready entry. Age is unique, so exactly one entry qualifies. issue_valid = OR of all ready flags. When issue_valid=0, issue_idx=0.
- Latency:
  - An entry dispatched with both operands valid is offerable the cycle after its dispatch edge.
  - An entry woken at edge k is offerable in cycle k+1.
  - There is no same-cycle dispatch-to-issue path.
- Issue fires on an edge with issue_valid & issue_ready. That entry's busy is cleared and its column is cleared in the age matrix. The freed entry becomes allocatable the next cycle.
- Stall: while issue_ready=0, issue_idx may change if an older entry becomes ready. The ALU samples issue_idx only on the accept edge.
- Dispatch and issue on the same edge are both performed. The dispatch index comes from the pre-edge free set, so it never equals the issuing entry.
- Full: disp_ready=0, and disp_valid is ignored with no state change.
- Empty: issue_valid=0, and issue_ready is ignored.
- Flush: takes priority over dispatch, issue and wakeup on the same edge. All busy flags clear; the next cycle shows the reset-equivalent outputs.
- Reset asserted mid-operation clears state immediately, independent of clk.
- free_count = ENTRIES minus the popcount of busy_mask.

Test Plan:
1. Reset, then dispatch 8 entries with va=vb=1 and issue_ready=0.
   - disp_idx runs 0..7; after the 8th edge, disp_ready=0 and free_count=0.
   - A 9th disp_valid leaves busy_mask=0xFF.
2. From the full state of test 1, hold issue_ready=1 for 8 cycles.
   - issue_idx sequence is 0,1,...,7 (oldest first).
   - Ends with busy_mask=0x00 and free_count=8.
3. Dispatch entry 0 with tags A=5/va=0, B=9/vb=1, then entry 1 with va=vb=1.
   - issue_valid offers idx 1.
   - Broadcast cdb_tag=5: in the next cycle idx 0 is offered ahead of a still-waiting idx 1 (entry 0 is older).
4. Dispatch with disp_tag_a=12, va=0 while cdb_valid=1, cdb_tag=12 on the same edge.
   - The entry is ready the next cycle; issue_valid=1 with that index.
5. With entries 0..7 busy and only entry 3 ready, assert issue_ready and disp_valid together.
   - Entry 3 issues; dispatch is refused (disp_ready was 0).
   - Next cycle disp_ready=1, disp_idx=3, free_count=1.
6. With 5 busy entries, assert flush together with disp_valid and issue_ready.
   - Next cycle busy_mask=0, free_count=8, issue_valid=0.
   - Separately, drive reset low between clock edges: busy_mask=0 without waiting for a clk edge.
